paddle_input_ctrl: RTL and testbench

Multi-channel button front end for the pong paddles.
- Synchronises N raw push-buttons and debounces them from one shared sample-tick prescaler.
- Produces clean levels, one-cycle press/release pulses and paddle-move pulses with hold-to-repeat.
- Sits between the board buttons and the paddle position logic.

---
 rtl/paddle_input_pkg.sv | 40 ++++
 rtl/paddle_input_ctrl_if.sv | 31 +++
 rtl/paddle_input_chan.sv | 166 ++++++++++++++++
 rtl/paddle_input_ctrl.sv | 78 +++++++
 tb/tb_paddle_input_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/paddle_input_pkg.sv
// -----------------------------------------------------------------------------
// paddle_input_pkg
// Shared types and width helpers for the paddle button front end.
//   rep_state_e : per-channel auto-repeat state
//   presc_w()   : width of the sample-tick prescaler counter
//   stab_w()    : width of the per-channel debounce stability counter
//   rep_w()     : width of the per-channel repeat counter
// -----------------------------------------------------------------------------
package paddle_input_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rep_state_e;

  localparam int DEF_N_BTN        = 4;
  localparam int DEF_TICK_DIV     = 25000;
  localparam int DEF_STABLE_TICKS = 10;
  localparam int DEF_REPEAT_DELAY = 300;
  localparam int DEF_REPEAT_RATE  = 50;

  // Prescaler holds 0..tick_div-1.
  function automatic int presc_w(input int tick_div);
    return (tick_div > 2) ? $clog2(tick_div) : 1;
  endfunction

  // Stability counter must be able to hold stable_ticks.
  function automatic int stab_w(input int stable_ticks);
    return (stable_ticks > 0) ? $clog2(stable_ticks + 1) : 1;
  endfunction

  // Repeat counter covers the larger of the two repeat intervals.
  function automatic int rep_w(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// paddle_input_ctrl_if
// Button-side bundle of the paddle input controller.
//   i_btn     : raw buttons into the controller (1 = pressed)
//   o_level   : debounced level per channel
//   o_press   : one-cycle pulse on accepted press
//   o_release : one-cycle pulse on accepted release
//   o_move    : one-cycle paddle-step pulse (press and auto-repeat)
//   o_tick    : one-cycle sample-tick strobe
// Modports: slave = the controller, master = the board/paddle-logic side.
// -----------------------------------------------------------------------------
interface paddle_input_ctrl_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_move;
  logic             o_tick;

  modport slave (
    input  i_btn,
    output o_level, o_press, o_release, o_move, o_tick
  );

  modport master (
    output i_btn,
    input  o_level, o_press, o_release, o_move, o_tick
  );
endinterface

// File: rtl/paddle_input_chan.sv
// -----------------------------------------------------------------------------
// paddle_input_chan
// One button channel: 2-flop synchroniser, tick-sampled debounce counter,
// registered press/release pulses and the hold-to-repeat FSM.
// Build option: AUTO_REPEAT_EN
//   defined   -> repeat FSM + rep_cnt present, o_move pulses on press and
//                then after REPEAT_DELAY ticks, every REPEAT_RATE ticks
//   undefined -> no repeat logic, o_move is the press pulse
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_tick         : shared sample-tick strobe
//   i_btn          : raw asynchronous button
//   o_level, o_press, o_release, o_move : channel outputs
// -----------------------------------------------------------------------------
module paddle_input_chan
  import paddle_input_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_move
);

  if (STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("paddle_input_chan: STABLE_TICKS, REPEAT_DELAY, REPEAT_RATE must be >= 1");
  end

  localparam int STAB_W = stab_w(STABLE_TICKS);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              accept;

  // Synchroniser and debounce. The counter saturates at STAB_LAST because
  // reaching it either accepts the new level or is cleared by a match.
  always_comb begin
    sync1_d    = i_btn;
    sync2_d    = sync1_q;
    level_d    = level_q;
    stab_cnt_d = stab_cnt_q;
    accept     = 1'b0;
    if (i_tick) begin
      if (sync2_q != level_q) begin
        if (stab_cnt_q == STAB_LAST) begin
          accept     = 1'b1;
          level_d    = sync2_q;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end else begin
        stab_cnt_d = '0;
      end
    end
    press_d   = accept & sync2_q;
    release_d = accept & ~sync2_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      stab_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      stab_cnt_q <= stab_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = rep_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  rep_state_e       state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             move_q, move_d;

  // Repeat FSM advances on tick cycles only, so o_move can fire at most once
  // per tick. A release accepted in the same tick wins over an expiring
  // repeat interval.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    move_d    = 1'b0;
    if (i_tick) begin
      if (release_d) begin
        state_d   = RELEASED;
        rep_cnt_d = '0;
      end else begin
        case (state_q)
          RELEASED: begin
            if (press_d) begin
              state_d   = HELD_DELAY;
              rep_cnt_d = '0;
              move_d    = 1'b1;
            end
          end
          HELD_DELAY: begin
            if (rep_cnt_q == DELAY_LAST) begin
              state_d   = HELD_REPEAT;
              rep_cnt_d = '0;
              move_d    = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          HELD_REPEAT: begin
            if (rep_cnt_q == RATE_LAST) begin
              rep_cnt_d = '0;
              move_d    = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d   = RELEASED;
            rep_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RELEASED;
      rep_cnt_q <= '0;
      move_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      move_q    <= move_d;
    end
  end

  assign o_move = move_q;
`else
  assign o_move = press_q;
`endif

endmodule

// File: rtl/paddle_input_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_input_ctrl
// Multi-channel button front end for the pong paddles: a shared sample-tick
// prescaler plus N_BTN independent debounce/pulse/repeat channels.
// Build option: AUTO_REPEAT_EN enables hold-to-repeat on o_move; without it
// o_move equals o_press.
// i_rst_n asserts asynchronously; its release is expected to be synchronous
// to i_clk so that the first tick lands exactly TICK_DIV cycles later.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : paddle_input_ctrl_if.slave (i_btn in; o_level, o_press,
//             o_release, o_move, o_tick out)
// -----------------------------------------------------------------------------
module paddle_input_ctrl
  import paddle_input_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  paddle_input_ctrl_if.slave  bus
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("paddle_input_ctrl: TICK_DIV must be >= 2");
  end

  localparam int PRESC_W = presc_w(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;
  logic [N_BTN-1:0]   level_w, press_w, release_w, move_w;

  // Tick is decoded straight from the count so it is high during the
  // cycle in which the count sits at TICK_DIV-1.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    paddle_input_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_tick    (tick),
      .i_btn     (bus.i_btn[i]),
      .o_level   (level_w[i]),
      .o_press   (press_w[i]),
      .o_release (release_w[i]),
      .o_move    (move_w[i])
    );
  end

  assign bus.o_level   = level_w;
  assign bus.o_press   = press_w;
  assign bus.o_release = release_w;
  assign bus.o_move    = move_w;
  assign bus.o_tick    = tick;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
`timescale 1ns/1ps
module tb_paddle_input_ctrl;
  localparam int N_BTN        = 2;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  paddle_input_ctrl_if #(.N_BTN(N_BTN)) bus ();

  paddle_input_ctrl #(
    .N_BTN        (N_BTN),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {level, press, release, move}, two bits each
  function automatic logic [7:0] outs();
    return {bus.o_level, bus.o_press, bus.o_release, bus.o_move};
  endfunction

  function automatic logic [7:0] tk();
    return {7'b0, bus.o_tick};
  endfunction

  // Advance n rising edges, then sit on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Stop on a falling edge where the tick is high (next edge is a tick edge).
  task automatic wait_tick();
    int k = 0;
    while (bus.o_tick !== 1'b1 && k < 2 * TICK_DIV) begin
      cyc(1);
      k++;
    end
    chk("tick_wait", tk(), 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200us");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    logic [1:0] mv;
    bus.i_btn = '0;
    #2 rst_n = 1'b0;
    cyc(3);
    chk("rst_outs", outs(), 8'h00);
    chk("rst_tick", tk(), 8'h00);
    rst_n = 1'b1;

    // Idle: tick every 4th cycle, first at cycle 3; nothing else moves.
    for (int c = 1; c <= 100; c++) begin
      cyc(1);
      chk("idle_tick", tk(), {7'b0, (c % 4 == 3)});
      chk("idle_outs", outs(), 8'h00);
    end

    // Channel 0 press: sync2 seen on ticks P4, P8, accepted on P12.
    wait_tick();
    bus.i_btn = 2'b01;
    cyc(12);
    chk("press0_pre", outs(), 8'h00);
    cyc(1);
    chk("press0", outs(), {2'b01, 2'b01, 2'b00, 2'b01});
    cyc(1);
    chk("press0_end", outs(), {2'b01, 2'b00, 2'b00, 2'b00});

    // Channel 0 release (accepted before any repeat expiry).
    wait_tick();
    bus.i_btn = 2'b00;
    cyc(12);
    chk("rel0_pre", outs(), {2'b01, 2'b00, 2'b00, 2'b00});
    cyc(1);
    chk("rel0", outs(), {2'b00, 2'b00, 2'b01, 2'b00});

    // Glitches: high one tick, low one tick -> never qualifies.
    wait_tick();
    for (int r = 0; r < 10; r++) begin
      bus.i_btn = 2'b01;
      for (int j = 0; j < 4; j++) begin cyc(1); chk("glitch_hi", outs(), 8'h00); end
      bus.i_btn = 2'b00;
      for (int j = 0; j < 4; j++) begin cyc(1); chk("glitch_lo", outs(), 8'h00); end
    end

    // Channel 1 held: moves at tick offsets 0, 5, 7, ..., 19 (repeat build).
    wait_tick();
    bus.i_btn = 2'b10;
    cyc(12);
    chk("press1_pre", outs(), 8'h00);
    cyc(1);
    chk("press1", outs(), {2'b10, 2'b10, 2'b00, 2'b10});
    for (int k = 1; k <= 20; k++) begin
      for (int j = 1; j <= 4; j++) begin
        cyc(1);
        mv = (AUTO && j == 4 && k >= 5 && (k % 2) == 1) ? 2'b10 : 2'b00;
        chk("hold1", outs(), {2'b10, 2'b00, 2'b00, mv});
      end
    end

    // Release at tick 20: one more repeat at 21, release accepted at 23
    // where a repeat would also expire -> release wins, no move.
    bus.i_btn = 2'b00;
    for (int k = 21; k <= 23; k++) begin
      for (int j = 1; j <= 4; j++) begin
        cyc(1);
        mv = (AUTO && j == 4 && k == 21) ? 2'b10 : 2'b00;
        if (k == 23 && j == 4) e = {2'b00, 2'b00, 2'b10, mv};
        else                   e = {2'b10, 2'b00, 2'b00, mv};
        chk("rel1", outs(), e);
      end
    end
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      chk("rel1_quiet", outs(), 8'h00);
    end

    // Reset mid-hold with the button kept pressed.
    wait_tick();
    bus.i_btn = 2'b01;
    cyc(13);
    chk("press0_b", outs(), {2'b01, 2'b01, 2'b00, 2'b01});
    cyc(6);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 8'h00);
    chk("rst_async_tick", tk(), 8'h00);
    cyc(2);
    chk("rst_hold_outs", outs(), 8'h00);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      chk("post_rst_tick", tk(), {7'b0, (c % 4 == 3)});
      e = (c == 12) ? {2'b01, 2'b01, 2'b00, 2'b01} : 8'h00;
      chk("post_rst_outs", outs(), e);
    end
    cyc(1);
    chk("post_rst_end", outs(), {2'b01, 2'b00, 2'b00, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
